// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, exception bit positions,
// default-format constants and the operand classifier.
package fp_pkg;

  localparam int FP_NEXP     = 8;
  localparam int FP_NSIG     = 7;
  localparam int FP_W        = FP_NEXP + FP_NSIG + 1;
  localparam int NTYPES      = 6;
  localparam int NEXCEPTIONS = 5;

  typedef enum logic [2:0] {
    ZERO,
    SUBNORMAL,
    NORMAL,
    INF,
    QNAN,
    SNAN
  } fp_class_e;

  // Exception vector is {invalid, divzero, overflow, underflow, inexact}
  localparam int EXC_INEXACT   = 0;
  localparam int EXC_UNDERFLOW = 1;
  localparam int EXC_OVERFLOW  = 2;
  localparam int EXC_DIVZERO   = 3;
  localparam int EXC_INVALID   = 4;

  localparam int BIAS = (1 << (FP_NEXP - 1)) - 1;
  localparam logic [FP_W-1:0] CANON_QNAN =
    {1'b0, {FP_NEXP{1'b1}}, 1'b1, {(FP_NSIG-1){1'b0}}};

  // Width-agnostic: callers reduce their exponent/fraction fields to flags
  function automatic fp_class_e fp_classify(
    input logic exp_zero,
    input logic exp_ones,
    input logic frac_zero,
    input logic frac_msb
  );
    fp_class_e c;
    if (exp_zero) begin
      if (frac_zero) c = ZERO;
      else           c = SUBNORMAL;
    end else if (exp_ones) begin
      if (frac_zero)     c = INF;
      else if (frac_msb) c = QNAN;
      else               c = SNAN;
    end else begin
      c = NORMAL;
    end
    return c;
  endfunction

  function automatic logic [NTYPES-1:0] class_onehot(input fp_class_e c);
    return NTYPES'(1) << c;
  endfunction

endpackage

// File: rtl/fp_round_ne.sv
// Normalises the raw restoring-division quotient, rounds to nearest-even and
// saturates to signed inf / signed zero on exponent overflow / underflow.
module fp_round_ne
  import fp_pkg::*;
#(
  parameter int NEXP = FP_NEXP,
  parameter int NSIG = FP_NSIG,
  localparam int W  = NEXP + NSIG + 1,
  localparam int QW = NSIG + 3,
  localparam int EW = NEXP + 2
) (
  input  logic [QW-1:0]          i_quo,
  input  logic                   i_rem_nz,
  input  logic signed [EW-1:0]   i_exp,
  input  logic                   i_sign,
  output logic [W-1:0]           o_res,
  output logic [NEXCEPTIONS-1:0] o_exc
);

  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << NEXP) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  // Hidden bit is dropped: after normalisation it is always 1
  logic [QW-2:0]        w_norm;
  logic signed [EW-1:0] w_exp_n;
  logic signed [EW-1:0] w_exp_r;
  logic                 w_guard;
  logic                 w_sticky;
  logic                 w_inc;
  logic [NSIG:0]        w_frac_sum;

  always_comb begin
    w_norm     = i_quo[QW-1] ? i_quo[QW-2:0] : (i_quo[QW-2:0] << 1);
    w_exp_n    = i_quo[QW-1] ? i_exp : (i_exp - EW'(1));
    w_guard    = w_norm[1];
    w_sticky   = w_norm[0] | i_rem_nz;
    w_inc      = w_guard & (w_norm[2] | w_sticky);
    // A carry out leaves the low fraction bits at zero, giving 1.0 x 2^(e+1)
    w_frac_sum = {1'b0, w_norm[QW-2:2]} + (NSIG+1)'(w_inc);
    w_exp_r    = w_exp_n + EW'(w_frac_sum[NSIG]);

    o_exc              = '0;
    o_exc[EXC_INEXACT] = w_guard | w_sticky;
    if (w_exp_r >= EXP_MAX) begin
      o_res               = {i_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
      o_exc[EXC_OVERFLOW] = 1'b1;
      o_exc[EXC_INEXACT]  = 1'b1;
    end else if (w_exp_r <= EXP_ZERO) begin
      o_res                = {i_sign, {(W-1){1'b0}}};
      o_exc[EXC_UNDERFLOW] = 1'b1;
      o_exc[EXC_INEXACT]   = 1'b1;
    end else begin
      o_res = {i_sign, w_exp_r[NEXP-1:0], w_frac_sum[NSIG-1:0]};
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential floating-point divider: classify, restoring significand division
// one quotient bit per cycle, then round-nearest-even. One operation in flight.
module fp_div_seq
  import fp_pkg::*;
#(
  parameter int NEXP = FP_NEXP,
  parameter int NSIG = FP_NSIG,
  localparam int W = NEXP + NSIG + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           a,
  input  logic [W-1:0]           b,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           q,
  output logic [NTYPES-1:0]      q_class,
  output logic [NEXCEPTIONS-1:0] exception
);

  localparam int QW = NSIG + 3;
  localparam int EW = NEXP + 2;
  localparam int CW = $clog2(NSIG + 4);

  typedef enum logic [2:0] {IDLE, CLASSIFY, ITER, ROUND, DONE} state_e;

  state_e                 r_state;
  logic [W-1:0]           r_a;
  logic [W-1:0]           r_b;
  logic                   r_sign;
  logic signed [EW-1:0]   r_exp;
  logic [QW-1:0]          r_rem;
  logic [NSIG:0]          r_div;
  logic [QW-1:0]          r_quo;
  logic [CW-1:0]          r_cnt;
  logic                   r_out_valid;
  logic [W-1:0]           r_q;
  logic [NTYPES-1:0]      r_q_class;
  logic [NEXCEPTIONS-1:0] r_exc;

  function automatic logic [NTYPES-1:0] onehot_of(input logic [W-1:0] v);
    logic [NEXP-1:0] e;
    logic [NSIG-1:0] f;
    e = v[W-2:NSIG];
    f = v[NSIG-1:0];
    return class_onehot(fp_classify(e == '0, &e, f == '0, f[NSIG-1]));
  endfunction

  logic [NEXP-1:0] w_ea, w_eb;
  logic [NSIG-1:0] w_fa, w_fb;
  fp_class_e       w_cls_a, w_cls_b;
  logic            w_sign;

  assign w_ea    = r_a[W-2:NSIG];
  assign w_eb    = r_b[W-2:NSIG];
  assign w_fa    = r_a[NSIG-1:0];
  assign w_fb    = r_b[NSIG-1:0];
  assign w_sign  = r_a[W-1] ^ r_b[W-1];
  assign w_cls_a = fp_classify(w_ea == '0, &w_ea, w_fa == '0, w_fa[NSIG-1]);
  assign w_cls_b = fp_classify(w_eb == '0, &w_eb, w_fb == '0, w_fb[NSIG-1]);

  // Subnormals flush to signed zero, so they share the zero rules
  logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_any_snan;
  assign w_a_zero   = (w_cls_a == ZERO) || (w_cls_a == SUBNORMAL);
  assign w_b_zero   = (w_cls_b == ZERO) || (w_cls_b == SUBNORMAL);
  assign w_a_inf    = (w_cls_a == INF);
  assign w_b_inf    = (w_cls_b == INF);
  assign w_a_nan    = (w_cls_a == QNAN) || (w_cls_a == SNAN);
  assign w_b_nan    = (w_cls_b == QNAN) || (w_cls_b == SNAN);
  assign w_any_snan = (w_cls_a == SNAN) || (w_cls_b == SNAN);

  logic                   w_special;
  logic [W-1:0]           w_spec_res;
  logic [NEXCEPTIONS-1:0] w_spec_exc;

  always_comb begin
    w_special  = 1'b1;
    w_spec_res = '0;
    w_spec_exc = '0;
    if (w_a_nan || w_b_nan) begin
      w_spec_res              = CANON_QNAN;
      w_spec_exc[EXC_INVALID] = w_any_snan;
    end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_res              = CANON_QNAN;
      w_spec_exc[EXC_INVALID] = 1'b1;
    end else if (w_a_inf) begin
      w_spec_res = {w_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
    end else if (w_b_zero) begin
      w_spec_res              = {w_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
      w_spec_exc[EXC_DIVZERO] = 1'b1;
    end else if (w_a_zero || w_b_inf) begin
      w_spec_res = {w_sign, {(W-1){1'b0}}};
    end else begin
      w_special = 1'b0;
    end
  end

  // Biased-exponent difference cannot wrap: range is [1-254+127, 254-1+127]
  logic [EW-1:0] w_exp_init;
  assign w_exp_init = EW'(w_ea) - EW'(w_eb) + EW'(BIAS);

  logic [QW-1:0] w_div_ext;
  logic          w_ge;
  logic [QW-1:0] w_rem_sub;
  assign w_div_ext = {2'b00, r_div};
  assign w_ge      = (r_rem >= w_div_ext);
  assign w_rem_sub = w_ge ? (r_rem - w_div_ext) : r_rem;

  logic [W-1:0]           w_rnd_res;
  logic [NEXCEPTIONS-1:0] w_rnd_exc;

  fp_round_ne #(
    .NEXP(NEXP),
    .NSIG(NSIG)
  ) u_round (
    .i_quo    (r_quo),
    .i_rem_nz (r_rem != '0),
    .i_exp    (r_exp),
    .i_sign   (r_sign),
    .o_res    (w_rnd_res),
    .o_exc    (w_rnd_exc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_q         <= '0;
      r_q_class   <= class_onehot(ZERO);
      r_exc       <= '0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_state <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          if (w_special) begin
            r_q         <= w_spec_res;
            r_q_class   <= onehot_of(w_spec_res);
            r_exc       <= w_spec_exc;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_sign  <= w_sign;
            r_exp   <= w_exp_init;
            r_rem   <= {2'b00, 1'b1, w_fa};
            r_div   <= {1'b1, w_fb};
            r_quo   <= '0;
            r_cnt   <= CW'(NSIG + 3);
            r_state <= ITER;
          end
        end
        ITER: begin
          r_rem <= w_rem_sub << 1;
          r_quo <= {r_quo[QW-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= ROUND;
        end
        ROUND: begin
          r_q         <= w_rnd_res;
          r_q_class   <= onehot_of(w_rnd_res);
          r_exc       <= w_rnd_exc;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign q         = r_q;
  assign q_class   = r_q_class;
  assign exception = r_exc;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed and randomised checks of fp_div_seq against an arithmetic model
// built from exact integer long division.
module tb_fp_div_seq;
  import fp_pkg::*;

  localparam int W = FP_W;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [W-1:0]           a;
  logic [W-1:0]           b;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [W-1:0]           q;
  logic [NTYPES-1:0]      q_class;
  logic [NEXCEPTIONS-1:0] exception;

  int n_cmp  = 0;
  int n_fail = 0;

  fp_div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .q_class   (q_class),
    .exception (exception)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [NTYPES-1:0] ref_class(input logic [15:0] v);
    int e, f;
    fp_class_e c;
    e = int'(v[14:7]);
    f = int'(v[6:0]);
    if (e == 0)        c = (f == 0) ? ZERO : SUBNORMAL;
    else if (e == 255) c = (f == 0) ? INF : (v[6] ? QNAN : SNAN);
    else               c = NORMAL;
    return 6'b000001 << int'(c);
  endfunction

  // Value-level model: exact quotient, RNE on the integer remainder
  task automatic ref_div(input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] rq, output logic [4:0] rx, output int rlat);
    int ex, ey, fx, fy, e, num, den, sig, r;
    logic s, xnan, ynan, xsn, ysn, xinf, yinf, xz, yz;
    ex = int'(x[14:7]); fx = int'(x[6:0]);
    ey = int'(y[14:7]); fy = int'(y[6:0]);
    s    = x[15] ^ y[15];
    xnan = (ex == 255) && (fx != 0); ynan = (ey == 255) && (fy != 0);
    xsn  = xnan && !x[6];            ysn  = ynan && !y[6];
    xinf = (ex == 255) && (fx == 0); yinf = (ey == 255) && (fy == 0);
    xz   = (ex == 0);                yz   = (ey == 0);
    rx = 5'b0;
    rlat = 2;
    if (xnan || ynan) begin
      rq = 16'h7FC0; rx[4] = xsn || ysn;
    end else if ((xz && yz) || (xinf && yinf)) begin
      rq = 16'h7FC0; rx[4] = 1'b1;
    end else if (xinf) begin
      rq = {s, 15'h7F80};
    end else if (yz) begin
      rq = {s, 15'h7F80}; rx[3] = 1'b1;
    end else if (xz || yinf) begin
      rq = {s, 15'h0000};
    end else begin
      rlat = 13;
      num = 128 + fx;
      den = 128 + fy;
      e = ex - ey + 127;
      if (num >= den) num = num * 128;
      else begin num = num * 256; e = e - 1; end
      sig = num / den;
      r   = num % den;
      if ((2 * r > den) || ((2 * r == den) && (sig % 2 == 1))) sig = sig + 1;
      if (sig == 256) begin sig = 128; e = e + 1; end
      if (e >= 255) begin
        rq = {s, 15'h7F80}; rx = 5'b00101;
      end else if (e <= 0) begin
        rq = {s, 15'h0000}; rx = 5'b00011;
      end else begin
        rq = {s, e[7:0], sig[6:0]}; rx[0] = (r != 0);
      end
    end
  endtask

  task automatic accept(input logic [15:0] x, input logic [15:0] y);
    int guard = 0;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input int hold, input logic [15:0] eq, input logic [4:0] ex,
                        input int elat);
    int lat;
    accept(x, y);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s %h/%h latency", tag, x, y), 32'(lat), 32'(elat));
    check($sformatf("%s %h/%h q", tag, x, y), 32'(q), 32'(eq));
    check($sformatf("%s %h/%h class", tag, x, y), 32'(q_class), 32'(ref_class(eq)));
    check($sformatf("%s %h/%h exc", tag, x, y), 32'(exception), 32'(ex));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s hold q", tag), 32'(q), 32'(eq));
      check($sformatf("%s hold out_valid", tag), 32'(out_valid), 32'd1);
      check($sformatf("%s hold in_ready", tag), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("%s out_valid drop", tag), 32'(out_valid), 32'd0);
    check($sformatf("%s in_ready back", tag), 32'(in_ready), 32'd1);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 11))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'h7F80;
      3: return 16'hFF80;
      4: return 16'h7FC0;
      5: return 16'h7F81;
      6: return 16'h0001;
      default: return 16'($urandom());
    endcase
  endfunction

  initial begin
    logic [15:0] x, y, eq;
    logic [4:0]  ex;
    int          elat, lat, seen;

    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    a = '0; b = '0;
    #1 rst_n = 1'b0;
    #2;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset q", 32'(q), 32'd0);
    check("reset q_class", 32'(q_class), 32'h01);
    check("reset exception", 32'(exception), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("six_by_two", 16'h40C0, 16'h4000, 0, 16'h4040, 5'h00, 13);
    run_op("one_third",  16'h3F80, 16'h4040, 5, 16'h3EAB, 5'h01, 13);
    run_op("divzero",    16'h3F80, 16'h0000, 0, 16'h7F80, 5'h08, 2);
    run_op("zero_zero",  16'h0000, 16'h0000, 0, 16'h7FC0, 5'h10, 2);
    run_op("overflow",   16'h7F7F, 16'h3F00, 0, 16'h7F80, 5'h05, 13);
    run_op("underflow",  16'h0080, 16'h4000, 0, 16'h0000, 5'h03, 13);
    run_op("exp_hi",     16'h7F00, 16'h0080, 0, 16'h7F80, 5'h05, 13);
    run_op("exp_lo",     16'h0080, 16'h7F00, 1, 16'h0000, 5'h03, 13);
    run_op("snan",       16'h7F81, 16'h3F80, 0, 16'h7FC0, 5'h10, 2);
    run_op("inf_inf",    16'hFF80, 16'h7F80, 0, 16'h7FC0, 5'h10, 2);
    run_op("inf_fin",    16'hFF80, 16'h4000, 0, 16'hFF80, 5'h00, 2);
    run_op("fin_inf",    16'h4000, 16'hFF80, 0, 16'h8000, 5'h00, 2);
    run_op("subn_div",   16'h0001, 16'hC000, 0, 16'h8000, 5'h00, 2);
    run_op("neg_norm",   16'hC0C0, 16'h4000, 0, 16'hC040, 5'h00, 13);

    // Flush during the fourth ITER cycle
    accept(16'h3F80, 16'h4040);
    lat = 1;
    while (lat < 5) begin
      @(negedge clk);
      lat++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_iter in_ready", 32'(in_ready), 32'd1);
    check("flush_iter out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush_iter no_result", 32'(seen), 32'd0);
    run_op("after_flush", 16'h3F80, 16'h3F80, 0, 16'h3F80, 5'h00, 13);

    // Flush while a result is waiting
    accept(16'h40C0, 16'h4000);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("flush_done reached", 32'(out_valid), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_done out_valid", 32'(out_valid), 32'd0);
    check("flush_done in_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset mid-ITER after a result has been produced
    accept(16'h3F80, 16'h4040);
    lat = 1;
    while (lat < 6) begin
      @(negedge clk);
      lat++;
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid out_valid", 32'(out_valid), 32'd0);
    check("rst_mid q", 32'(q), 32'd0);
    check("rst_mid q_class", 32'(q_class), 32'h01);
    check("rst_mid exception", 32'(exception), 32'd0);
    check("rst_mid in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_rst", 16'h40C0, 16'h4000, 0, 16'h4040, 5'h00, 13);

    for (int i = 0; i < 150; i++) begin
      x = pick();
      y = pick();
      ref_div(x, y, eq, ex, elat);
      run_op("rnd", x, y, int'($urandom_range(0, 2)), eq, ex, elat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Multi-cycle sequencer for floating-point division in the FPU, default format bfloat16 (1 sign, NEXP exponent, NSIG fraction bits).
- Accepts one operand pair over a valid/ready handshake and classifies both operands.
- Special cases resolve in a short path; normal operands run a restoring significand-division loop, one quotient bit per cycle, then normalise and round to nearest-even.
- Presents result, result class and exception flags over a valid/ready output.

Parameters:
NEXP, 8, exponent field width
NSIG, 7, stored fraction width; word width W = NEXP+NSIG+1

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  high only in IDLE
a  in  W  dividend
b  in  W  divisor
flush  in  1  synchronous abort; FSM returns to IDLE next cycle, result discarded
out_valid  out  1  result valid; held until out_ready
out_ready  in  1  consumer accepts
q  out  W  quotient
q_class  out  NTYPES  one-hot class of q
exception  out  NEXCEPTIONS  sticky-per-op flags {invalid, divzero, overflow, underflow, inexact}

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on rst_n.
- Reset values:
  - FSM = IDLE; out_valid = 0, q = 0, q_class = ZERO one-hot, exception = 0.
  - Iteration counter, quotient and remainder registers = 0.
  - Reset mid-operation drops the operation silently.
- FSM states: IDLE, CLASSIFY, ITER, ROUND, DONE.
  - IDLE: in_ready = 1. On in_valid, register a and b, then go to CLASSIFY.
  - CLASSIFY, special-case handling:
    - Subnormal inputs are treated as signed zero (flush-to-zero).
    - Either NaN → q = canonical qNaN, exp all 1s, fraction MSB 1, sign 0 (0x7FC0). An sNaN input also raises invalid.
    - 0/0 or inf/inf → qNaN, invalid.
    - finite nonzero / 0 → signed inf, divzero.
    - inf / finite → signed inf.
    - 0 / nonzero or finite / inf → signed zero.
    - Any special case → DONE.
    - Otherwise: sign = a.s ^ b.s; exponent e = ea − eb + BIAS, signed, NEXP+2 bits; remainder = 1.fa; divisor = 1.fb; count = NSIG+3; go to ITER.
  - ITER, one restoring step per cycle:
    - If rem ≥ div then rem −= div and the quotient bit is 1; else the bit is 0.
    - Then rem <<= 1 and count−−.
    - Bits are produced with weights 2^0 .. 2^−(NSIG+2). Leave when count reaches 0.
  - ROUND, normalise:
    - If the quotient MSB is 0, shift left 1 and e −= 1.
    - Guard = bit below the LSB; sticky = any lower bit, or remainder ≠ 0.
    - Round to nearest-even.
    - Carry-out of the fraction → e += 1, fraction = 0.
    - inexact = guard | sticky.
    - e ≥ 2^NEXP−1 → signed inf, overflow + inexact.
    - e ≤ 0 → signed zero, underflow + inexact.
  - DONE: out_valid = 1, outputs stable. On out_ready go to IDLE; in_ready rises the following cycle.
- Latency, counted from the accept edge t0:
  - Special-case path: out_valid at cycle 2.
  - Normal path: CLASSIFY at 1, ITER at 2..NSIG+4, ROUND at NSIG+5, out_valid at NSIG+6 (13 cycles at defaults).
- Throughput: no overlap, one operation in flight.
- flush has priority over every transition except reset. flush in DONE clears out_valid.
- exception and q_class are recomputed per operation and never accumulate across operations.
- Width rules:
  - Remainder register is NSIG+3 bits wide, so there is no overflow of 2·rem.
  - Exponent arithmetic is signed NEXP+2 bits; it must not wrap for the extremes (ea = 254, eb = 1) and (ea = 1, eb = 254).

Decomposition:
- Package fp_pkg:
  - NTYPES / NEXCEPTIONS and the class enum {ZERO, SUBNORMAL, NORMAL, INF, QNAN, SNAN}.
  - Exception bit indices.
  - BIAS, canonical qNaN constant.
  - Classify function.
- One sub-module: fp_round_ne, combinational normalise + round-nearest-even + overflow/underflow detection, instanced in ROUND.

Test Plan:
- 0x40C0 / 0x4000 (6/2) → q = 0x4040, q_class NORMAL, exception 0, out_valid exactly 13 cycles after accept.
- 0x3F80 / 0x4040 (1/3) → q = 0x3EAB, inexact only. Hold out_ready low 5 cycles → q stable, in_ready stays 0.
- 0x3F80 / 0x0000 → 0x7F80, divzero. 0x0000 / 0x0000 → 0x7FC0, invalid. Both with out_valid at cycle 2.
- 0x7F7F / 0x3F00 → 0x7F80, overflow + inexact. 0x0080 / 0x4000 → 0x0000, underflow + inexact.
- Abort cases: flush at ITER cycle 4 → no out_valid, in_ready = 1 next cycle, and a following 0x3F80 / 0x3F80 → 0x3F80. rst_n pulse mid-ITER → all outputs at reset values immediately.
